// File: rtl/round_key_sequencer.sv
// Iterative AES-128 key schedule: expands one cipher key into 11 stored round keys and streams them out.
// Optional feature macro: AES_KEY_REVERSE_EN enables reverse-order (round 10 -> 0) streaming via dir.
module round_key_sequencer #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key,
   input  logic         dir,
   input  logic         replay,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_index,
   output logic         rk_last,
   output logic         busy
);

   if (NR != 10) begin : g_nr_unsupported
      $error("round_key_sequencer: only NR=10 (AES-128) is supported");
   end

   localparam logic [3:0] LAST_RK = 4'(NR);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_STREAM = 2'd2
   } state_t;

   // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = 8'h00;
      aa  = a;
      for (int i = 0; i < 8; i++) begin
         acc = acc ^ (aa & {8{b[i]}});
         aa  = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // S-box computed as multiplicative inverse (x^254) followed by the affine transform
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] x3, x7, x15, x31, x63, x127, inv, res, rot;
      x3   = gf_mul(gf_mul(x, x), x);
      x7   = gf_mul(gf_mul(x3, x3), x);
      x15  = gf_mul(gf_mul(x7, x7), x);
      x31  = gf_mul(gf_mul(x15, x15), x);
      x63  = gf_mul(gf_mul(x31, x31), x);
      x127 = gf_mul(gf_mul(x63, x63), x);
      inv  = gf_mul(x127, x127);
      res  = 8'h63;
      rot  = inv;
      for (int i = 0; i < 5; i++) begin
         res = res ^ rot;
         rot = {rot[6:0], rot[7]};
      end
      return res;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] r;
      case (rnd)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // One AES-128 key-schedule round; byte 0 of the state sits in bits [127:120]
   function automatic logic [127:0] key_expansion(input logic [127:0] prev, input logic [3:0] rnd);
      logic [31:0] t, w0, w1, w2, w3;
      t  = {prev[23:0], prev[31:24]};
      t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon(rnd), 24'h000000};
      w0 = prev[127:96] ^ t;
      w1 = prev[95:64]  ^ w0;
      w2 = prev[63:32]  ^ w1;
      w3 = prev[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   state_t       state_r;
   logic [127:0] slot_r [0:10];
   logic [3:0]   cnt_r;
   logic [3:0]   ptr_r;
   logic         loaded_r;
   logic         rk_valid_r;
   logic [127:0] rk_data_r;
   logic [3:0]   rk_index_r;
   logic         rk_last_r;

   logic [127:0] exp_s;
   logic [3:0]   ptr_start_s;
   logic [3:0]   ptr_step_s;
   logic [3:0]   ptr_end_s;

   // cnt_r stays in 1..10, so the previous slot index is always valid
   assign exp_s = key_expansion(slot_r[cnt_r - 4'd1], cnt_r);

`ifdef AES_KEY_REVERSE_EN
   logic dir_r;

   assign ptr_start_s = dir ? LAST_RK : 4'd0;

   // Pointer direction and end point follow the order latched at stream request
   always_comb begin
      if (dir_r) begin
         ptr_step_s = ptr_r - 4'd1;
         ptr_end_s  = 4'd0;
      end else begin
         ptr_step_s = ptr_r + 4'd1;
         ptr_end_s  = LAST_RK;
      end
   end
`else
   logic unused_dir_s;

   assign unused_dir_s = dir;
   assign ptr_start_s  = 4'd0;
   assign ptr_step_s   = ptr_r + 4'd1;
   assign ptr_end_s    = LAST_RK;
`endif

   // Control FSM, slot store and registered round-key outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 4'd1;
         ptr_r      <= 4'd0;
         loaded_r   <= 1'b0;
         rk_valid_r <= 1'b0;
         rk_data_r  <= 128'd0;
         rk_index_r <= 4'd0;
         rk_last_r  <= 1'b0;
         for (int i = 0; i < 11; i++) begin
            slot_r[i] <= 128'd0;
         end
`ifdef AES_KEY_REVERSE_EN
         dir_r      <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               // A key offered together with replay takes priority
               if (key_valid) begin
                  slot_r[0] <= key;
                  cnt_r     <= 4'd1;
                  ptr_r     <= ptr_start_s;
                  state_r   <= ST_EXPAND;
`ifdef AES_KEY_REVERSE_EN
                  dir_r     <= dir;
`endif
               end else if (replay && loaded_r) begin
                  ptr_r     <= ptr_start_s;
                  state_r   <= ST_STREAM;
`ifdef AES_KEY_REVERSE_EN
                  dir_r     <= dir;
`endif
               end else begin
                  state_r   <= ST_IDLE;
               end
            end
            ST_EXPAND: begin
               slot_r[cnt_r] <= exp_s;
               if (cnt_r == LAST_RK) begin
                  loaded_r <= 1'b1;
                  state_r  <= ST_STREAM;
               end else begin
                  cnt_r    <= cnt_r + 4'd1;
               end
            end
            ST_STREAM: begin
               if (!rk_valid_r) begin
                  rk_valid_r <= 1'b1;
                  rk_data_r  <= slot_r[ptr_r];
                  rk_index_r <= ptr_r;
                  rk_last_r  <= (ptr_r == ptr_end_s);
               end else if (rk_ready) begin
                  if (rk_last_r) begin
                     rk_valid_r <= 1'b0;
                     rk_data_r  <= 128'd0;
                     rk_index_r <= 4'd0;
                     rk_last_r  <= 1'b0;
                     state_r    <= ST_IDLE;
                  end else begin
                     ptr_r      <= ptr_step_s;
                     rk_data_r  <= slot_r[ptr_step_s];
                     rk_index_r <= ptr_step_s;
                     rk_last_r  <= (ptr_step_s == ptr_end_s);
                  end
               end else begin
                  rk_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign key_ready = (state_r == ST_IDLE);
   assign busy      = (state_r != ST_IDLE);
   assign rk_valid  = rk_valid_r;
   assign rk_data   = rk_data_r;
   assign rk_index  = rk_index_r;
   assign rk_last   = rk_last_r;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed bench for round_key_sequencer using FIPS-197 key-schedule vectors.
// Honours AES_KEY_REVERSE_EN when the build defines it.
module tb_round_key_sequencer;

   logic         clk;
   logic         rst_n;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key;
   logic         dir;
   logic         replay;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_data;
   logic [3:0]   rk_index;
   logic         rk_last;
   logic         busy;

   int total;
   int bad;

   logic [127:0] fwd_tab [0:10];
   localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

`ifdef AES_KEY_REVERSE_EN
   localparam bit REV = 1'b1;
`else
   localparam bit REV = 1'b0;
`endif

   round_key_sequencer #(.NR(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key       (key),
      .dir       (dir),
      .replay    (replay),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk_data   (rk_data),
      .rk_index  (rk_index),
      .rk_last   (rk_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_key(input logic [127:0] k, input logic d);
      key       = k;
      dir       = d;
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      dir       = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      total++;
      if (key_ready !== 1'b1 || rk_valid !== 1'b0 || rk_data !== 128'd0 ||
          rk_index !== 4'd0 || rk_last !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_values got ready=%b valid=%b data=%h idx=%0d last=%b busy=%b exp 1 0 0 0 0 0",
                  key_ready, rk_valid, rk_data, rk_index, rk_last, busy);
      end
   endtask

   task automatic test_replay_ignored();
      replay = 1'b1;
      step();
      replay = 1'b0;
      for (int c = 0; c < 4; c++) begin
         total++;
         if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL replay_unloaded cyc%0d got valid=%b busy=%b exp valid=0 busy=0", c, rk_valid, busy);
         end
         step();
      end
   endtask

   task automatic test_forward();
      int n;
      int k;
      rk_ready = 1'b1;
      send_key(KEY_A, 1'b0);
      total++;
      if (busy !== 1'b1 || key_ready !== 1'b0) begin
         bad++;
         $display("FAIL fwd_accept got busy=%b ready=%b exp busy=1 ready=0", busy, key_ready);
      end
      n = 0;
      while (!rk_valid && n < 30) begin
         step();
         n++;
      end
      total++;
      if (n !== 11) begin
         bad++;
         $display("FAIL fwd_latency got=%0d exp=11", n);
      end
      k = 0;
      for (int c = 0; c < 30 && k < 11; c++) begin
         if (rk_valid) begin
            total++;
            if (rk_index !== 4'(k) || rk_data !== fwd_tab[k] || rk_last !== (k == 10)) begin
               bad++;
               $display("FAIL fwd_key%0d got idx=%0d data=%h last=%b exp idx=%0d data=%h last=%b",
                        k, rk_index, rk_data, rk_last, k, fwd_tab[k], (k == 10));
            end
            k++;
         end
         step();
      end
      total++;
      if (k !== 11 || rk_valid !== 1'b0 || key_ready !== 1'b1) begin
         bad++;
         $display("FAIL fwd_end got count=%0d valid=%b ready=%b exp count=11 valid=0 ready=1", k, rk_valid, key_ready);
      end
   endtask

   task automatic test_replay();
      int k;
      rk_ready = 1'b1;
      dir      = 1'b0;
      replay   = 1'b1;
      step();
      replay   = 1'b0;
      total++;
      if (rk_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL replay_accept got valid=%b busy=%b exp valid=0 busy=1", rk_valid, busy);
      end
      step();
      total++;
      if (rk_valid !== 1'b1) begin
         bad++;
         $display("FAIL replay_latency got valid=%b exp valid=1", rk_valid);
      end
      k = 0;
      for (int c = 0; c < 30 && k < 11; c++) begin
         if (rk_valid) begin
            total++;
            if (rk_index !== 4'(k) || rk_data !== fwd_tab[k] || rk_last !== (k == 10)) begin
               bad++;
               $display("FAIL replay_key%0d got idx=%0d data=%h last=%b exp idx=%0d data=%h",
                        k, rk_index, rk_data, rk_last, k, fwd_tab[k]);
            end
            k++;
         end
         step();
      end
      total++;
      if (k !== 11 || busy !== 1'b0) begin
         bad++;
         $display("FAIL replay_end got count=%0d busy=%b exp count=11 busy=0", k, busy);
      end
   endtask

   task automatic test_backpressure();
      int n;
      int k;
      rk_ready = 1'b0;
      send_key(KEY_A, 1'b0);
      n = 0;
      while (!rk_valid && n < 30) begin
         step();
         n++;
      end
      k = 0;
      for (int c = 0; c < 100 && k < 11; c++) begin
         rk_ready = ((c % 4) == 0) || ((c % 4) == 3);
         total++;
         if (rk_valid !== 1'b1 || rk_index !== 4'(k) || rk_data !== fwd_tab[k] || rk_last !== (k == 10)) begin
            bad++;
            $display("FAIL bp_cyc%0d got valid=%b idx=%0d data=%h last=%b exp valid=1 idx=%0d data=%h last=%b",
                     c, rk_valid, rk_index, rk_data, rk_last, k, fwd_tab[k], (k == 10));
         end
         if (rk_valid && rk_ready) begin
            k++;
         end
         step();
      end
      rk_ready = 1'b1;
      total++;
      if (k !== 11 || rk_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_end got count=%0d valid=%b busy=%b exp count=11 valid=0 busy=0", k, rk_valid, busy);
      end
   endtask

   task automatic test_reverse();
      int n;
      int k;
      int e;
      rk_ready = 1'b1;
      send_key(KEY_A, 1'b1);
      n = 0;
      while (!rk_valid && n < 30) begin
         step();
         n++;
      end
      k = 0;
      for (int c = 0; c < 30 && k < 11; c++) begin
         if (rk_valid) begin
            e = REV ? (10 - k) : k;
            total++;
            if (rk_index !== 4'(e) || rk_data !== fwd_tab[e] || rk_last !== (k == 10)) begin
               bad++;
               $display("FAIL rev_key%0d got idx=%0d data=%h last=%b exp idx=%0d data=%h last=%b",
                        k, rk_index, rk_data, rk_last, e, fwd_tab[e], (k == 10));
            end
            k++;
         end
         step();
      end
      total++;
      if (k !== 11 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rev_end got count=%0d busy=%b exp count=11 busy=0", k, busy);
      end
   endtask

   task automatic test_collision();
      int n;
      int k;
      rk_ready  = 1'b1;
      key       = 128'd0;
      dir       = 1'b0;
      key_valid = 1'b1;
      replay    = 1'b1;
      step();
      key_valid = 1'b0;
      replay    = 1'b0;
      n = 0;
      while (!rk_valid && n < 30) begin
         step();
         n++;
      end
      total++;
      if (n !== 11) begin
         bad++;
         $display("FAIL coll_latency got=%0d exp=11", n);
      end
      k = 0;
      for (int c = 0; c < 30 && k < 11; c++) begin
         if (rk_valid) begin
            total++;
            if (rk_index !== 4'(k)) begin
               bad++;
               $display("FAIL coll_idx%0d got=%0d exp=%0d", k, rk_index, k);
            end
            if (k == 0) begin
               total++;
               if (rk_data !== 128'd0) begin
                  bad++;
                  $display("FAIL coll_key0 got=%h exp=%h", rk_data, 128'd0);
               end
            end else if (k == 10) begin
               total++;
               if (rk_data !== ZERO_R10 || rk_last !== 1'b1) begin
                  bad++;
                  $display("FAIL coll_key10 got data=%h last=%b exp data=%h last=1", rk_data, rk_last, ZERO_R10);
               end
            end
            k++;
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      int n;
      int k;
      rk_ready = 1'b1;
      send_key(KEY_A, 1'b0);
      for (int c = 0; c < 4; c++) begin
         step();
      end
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_busy got=%b exp=1", busy);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (key_ready !== 1'b1 || rk_valid !== 1'b0 || rk_data !== 128'd0 ||
          rk_index !== 4'd0 || rk_last !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_values got ready=%b valid=%b data=%h idx=%0d last=%b busy=%b exp 1 0 0 0 0 0",
                  key_ready, rk_valid, rk_data, rk_index, rk_last, busy);
      end
      step();
      rst_n  = 1'b1;
      step();
      replay = 1'b1;
      step();
      replay = 1'b0;
      step();
      total++;
      if (rk_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_replay got valid=%b busy=%b exp valid=0 busy=0", rk_valid, busy);
      end
      send_key(KEY_A, 1'b0);
      n = 0;
      while (!rk_valid && n < 30) begin
         step();
         n++;
      end
      k = 0;
      for (int c = 0; c < 30 && k < 11; c++) begin
         if (rk_valid) begin
            total++;
            if (rk_index !== 4'(k) || rk_data !== fwd_tab[k]) begin
               bad++;
               $display("FAIL rstmid_key%0d got idx=%0d data=%h exp idx=%0d data=%h",
                        k, rk_index, rk_data, k, fwd_tab[k]);
            end
            k++;
         end
         step();
      end
      total++;
      if (k !== 11) begin
         bad++;
         $display("FAIL rstmid_count got=%0d exp=11", k);
      end
   endtask

   task automatic test_back_to_back();
      int first;
      int second;
      first     = -1;
      second    = -1;
      rk_ready  = 1'b1;
      key       = KEY_A;
      dir       = 1'b0;
      key_valid = 1'b1;
      for (int c = 0; c < 60 && second < 0; c++) begin
         if (key_ready) begin
            if (first < 0) begin
               first = c;
            end else begin
               second = c;
            end
         end
         step();
      end
      key_valid = 1'b0;
      total++;
      if (second - first !== 23) begin
         bad++;
         $display("FAIL b2b_spacing got=%0d exp=23", second - first);
      end
      for (int c = 0; c < 40 && busy; c++) begin
         step();
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_drain got busy=%b exp busy=0", busy);
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key       = 128'd0;
      dir       = 1'b0;
      replay    = 1'b0;
      rk_ready  = 1'b0;
      fwd_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fwd_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fwd_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fwd_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fwd_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fwd_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fwd_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fwd_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fwd_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fwd_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fwd_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      test_reset();
      test_replay_ignored();
      test_forward();
      test_replay();
      test_backpressure();
      test_reverse();
      test_collision();
      test_reset_mid();
      test_back_to_back();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
